// File: rtl/bicubic_result_checker_if.sv
// Bus bundle for the bicubic result checker: start/config, shared memory read port, status.
// The checker side uses the slave modport; the controller/memory side uses master.
interface bicubic_result_checker_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 16
);
  logic              START;
  logic [5:0]        TW;
  logic [5:0]        TH;
  logic              GUARD_EN;
  logic              RD;
  logic [ADDR_W-1:0] RA;
  logic [DATA_W-1:0] RQ;
  logic [DATA_W-1:0] G1Q;
  logic [DATA_W-1:0] G2Q;
  logic              BUSY;
  logic              DONE;
  logic              PASS;
  logic [CNT_W-1:0]  ERR_CNT;
  logic [ADDR_W-1:0] ERR_ADDR;
  logic              ERR_VALID;

  modport master (
    output START, TW, TH, GUARD_EN, RQ, G1Q, G2Q,
    input  RD, RA, BUSY, DONE, PASS, ERR_CNT, ERR_ADDR, ERR_VALID
  );

  modport slave (
    input  START, TW, TH, GUARD_EN, RQ, G1Q, G2Q,
    output RD, RA, BUSY, DONE, PASS, ERR_CNT, ERR_ADDR, ERR_VALID
  );
endinterface

// File: rtl/bicubic_result_checker.sv
// Raster-scans the result window (plus optional guard band) and compares each pixel against two goldens.
// One read per cycle, no backpressure; DONE rises N+RD_LAT+2 cycles after the accepted START.
module bicubic_result_checker #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 14,
  parameter int ROW_STRIDE = 128,
  parameter int RD_LAT     = 1,
  parameter int GUARD_ROW  = 100,
  parameter int GUARD_ROWS = 2,
  parameter int GUARD_COLS = 30,
  parameter int CNT_W      = 16
) (
  input logic                     CLK,
  input logic                     RST,
  bicubic_result_checker_if.slave bus
);

  localparam int COL_W = (GUARD_COLS > 63) ? $clog2(GUARD_COLS + 1) : 6;
  localparam bit GUARD_OK = (GUARD_ROWS > 0) && (GUARD_COLS > 0);
  localparam logic [ADDR_W-1:0] G_FIRST = ADDR_W'(GUARD_ROW);
  localparam logic [ADDR_W-1:0] G_LAST  = ADDR_W'(GUARD_ROW + GUARD_ROWS - 1);
  localparam logic [COL_W-1:0]  GC_LAST = COL_W'(GUARD_COLS - 1);
  localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT + 1);

  typedef enum logic [2:0] {IDLE, WIN, GUARD, DRAIN, FIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [5:0]        tw_q, tw_d;
  logic [5:0]        th_q, th_d;
  logic              guard_q, guard_d;
  logic [2:0]        drain_q, drain_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              err_valid_q, err_valid_d;
  logic              rd_pipe_q [RD_LAT];
  logic              rd_pipe_d [RD_LAT];
  logic [ADDR_W-1:0] ra_pipe_q [RD_LAT];
  logic [ADDR_W-1:0] ra_pipe_d [RD_LAT];

  logic [DATA_W-1:0] rq, g1q, g2q;
  logic [ADDR_W-1:0] pix_addr;
  logic [ADDR_W-1:0] row_last;
  logic [COL_W-1:0]  col_last;
  logic              mismatch;

  assign rq  = bus.RQ;
  assign g1q = bus.G1Q;
  assign g2q = bus.G2Q;

  // Row product wraps modulo 2^ADDR_W by design.
  assign pix_addr = (row_q * ADDR_W'(ROW_STRIDE)) + ADDR_W'(col_q);
  assign row_last = (state_q == GUARD) ? G_LAST  : (ADDR_W'(th_q) - ADDR_W'(1));
  assign col_last = (state_q == GUARD) ? GC_LAST : (COL_W'(tw_q) - COL_W'(1));
  assign mismatch = rd_pipe_q[RD_LAT-1] && (rq != g1q) && (rq != g2q);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    tw_d        = tw_q;
    th_d        = th_q;
    guard_d     = guard_q;
    drain_d     = '0;
    rd_d        = 1'b0;
    ra_d        = ra_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    err_addr_d  = err_addr_q;
    err_valid_d = err_valid_q;

    rd_pipe_d[0] = rd_q;
    ra_pipe_d[0] = ra_q;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
      ra_pipe_d[i] = ra_pipe_q[i-1];
    end

    if (mismatch) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
      if (!err_valid_q) begin
        err_addr_d  = ra_pipe_q[RD_LAT-1];
        err_valid_d = 1'b1;
      end
    end

    case (state_q)
      IDLE, FIN: begin
        if (bus.START) begin
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_cnt_d   = '0;
          err_addr_d  = '0;
          err_valid_d = 1'b0;
          busy_d      = 1'b1;
          tw_d        = bus.TW;
          th_d        = bus.TH;
          guard_d     = bus.GUARD_EN;
          col_d       = '0;
          // An empty window falls straight through to the guard band or the drain.
          if ((bus.TW != 6'd0) && (bus.TH != 6'd0)) begin
            state_d = WIN;
            row_d   = '0;
          end else if (bus.GUARD_EN && GUARD_OK) begin
            state_d = GUARD;
            row_d   = G_FIRST;
          end else begin
            state_d = DRAIN;
            row_d   = '0;
          end
        end
      end
      WIN, GUARD: begin
        rd_d = 1'b1;
        ra_d = pix_addr;
        if (col_q == col_last) begin
          col_d = '0;
          if (row_q == row_last) begin
            if ((state_q == WIN) && guard_q && GUARD_OK) begin
              state_d = GUARD;
              row_d   = G_FIRST;
            end else begin
              state_d = DRAIN;
            end
          end else begin
            row_d = row_q + ADDR_W'(1);
          end
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      DRAIN: begin
        drain_d = drain_q + 3'd1;
        // Last compare lands one edge before this one, so the count is final here.
        if (drain_q == DRAIN_LAST) begin
          state_d = FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_cnt_q == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      tw_q        <= '0;
      th_q        <= '0;
      guard_q     <= 1'b0;
      drain_q     <= '0;
      rd_q        <= 1'b0;
      ra_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      err_addr_q  <= '0;
      err_valid_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        rd_pipe_q[i] <= 1'b0;
        ra_pipe_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      tw_q        <= tw_d;
      th_q        <= th_d;
      guard_q     <= guard_d;
      drain_q     <= drain_d;
      rd_q        <= rd_d;
      ra_q        <= ra_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      err_addr_q  <= err_addr_d;
      err_valid_q <= err_valid_d;
      for (int i = 0; i < RD_LAT; i++) begin
        rd_pipe_q[i] <= rd_pipe_d[i];
        ra_pipe_q[i] <= ra_pipe_d[i];
      end
    end
  end

  assign bus.RD        = rd_q;
  assign bus.RA        = ra_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.PASS      = pass_q;
  assign bus.ERR_CNT   = err_cnt_q;
  assign bus.ERR_ADDR  = err_addr_q;
  assign bus.ERR_VALID = err_valid_q;

endmodule

// File: tb/tb_bicubic_result_checker.sv
// Directed bench for bicubic_result_checker: three instances (RD_LAT=1, RD_LAT=3, CNT_W=4)
// share one set of result/golden memory arrays; only the selected instance is started.
module tb_bicubic_result_checker;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  bicubic_result_checker_if #(.DATA_W(8), .ADDR_W(14), .CNT_W(16)) i1 ();
  bicubic_result_checker_if #(.DATA_W(8), .ADDR_W(14), .CNT_W(16)) i3 ();
  bicubic_result_checker_if #(.DATA_W(8), .ADDR_W(14), .CNT_W(4))  i4 ();

  bicubic_result_checker #(.RD_LAT(1), .CNT_W(16)) u1 (.CLK(CLK), .RST(RST), .bus(i1));
  bicubic_result_checker #(.RD_LAT(3), .CNT_W(16)) u3 (.CLK(CLK), .RST(RST), .bus(i3));
  bicubic_result_checker #(.RD_LAT(1), .CNT_W(4))  u4 (.CLK(CLK), .RST(RST), .bus(i4));

  logic [7:0] res_mem [16384];
  logic [7:0] g1_mem  [16384];
  logic [7:0] g2_mem  [16384];

  logic [13:0] ra_w [3];
  logic [7:0]  pr [3][3];
  logic [7:0]  p1 [3][3];
  logic [7:0]  p2 [3][3];

  assign ra_w[0] = i1.RA;
  assign ra_w[1] = i3.RA;
  assign ra_w[2] = i4.RA;

  always @(posedge CLK) begin
    for (int n = 0; n < 3; n++) begin
      pr[n][0] <= res_mem[ra_w[n]];
      p1[n][0] <= g1_mem[ra_w[n]];
      p2[n][0] <= g2_mem[ra_w[n]];
      for (int s = 1; s < 3; s++) begin
        pr[n][s] <= pr[n][s-1];
        p1[n][s] <= p1[n][s-1];
        p2[n][s] <= p2[n][s-1];
      end
    end
  end

  assign i1.RQ = pr[0][0];  assign i1.G1Q = p1[0][0];  assign i1.G2Q = p2[0][0];
  assign i3.RQ = pr[1][2];  assign i3.G1Q = p1[1][2];  assign i3.G2Q = p2[1][2];
  assign i4.RQ = pr[2][0];  assign i4.G1Q = p1[2][0];  assign i4.G2Q = p2[2][0];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int sel = 0;
  logic        s_rd, s_busy, s_done, s_pass, s_ev;
  logic [13:0] s_ra, s_addr;
  logic [15:0] s_cnt;

  always_comb begin
    s_rd = i1.RD; s_ra = i1.RA; s_busy = i1.BUSY; s_done = i1.DONE; s_pass = i1.PASS;
    s_cnt = i1.ERR_CNT; s_addr = i1.ERR_ADDR; s_ev = i1.ERR_VALID;
    if (sel == 1) begin
      s_rd = i3.RD; s_ra = i3.RA; s_busy = i3.BUSY; s_done = i3.DONE; s_pass = i3.PASS;
      s_cnt = i3.ERR_CNT; s_addr = i3.ERR_ADDR; s_ev = i3.ERR_VALID;
    end else if (sel == 2) begin
      s_rd = i4.RD; s_ra = i4.RA; s_busy = i4.BUSY; s_done = i4.DONE; s_pass = i4.PASS;
      s_cnt = 16'(i4.ERR_CNT); s_addr = i4.ERR_ADDR; s_ev = i4.ERR_VALID;
    end
  end

  logic [13:0] exp_ra [128];
  int mon_idx = 0;
  int ra_bad  = 0;
  int rd_base = 0;
  int bad_base = 0;

  always @(negedge CLK) begin
    if (s_rd === 1'b1) begin
      if (s_ra !== exp_ra[(mon_idx - rd_base) & 127]) ra_bad = ra_bad + 1;
      mon_idx = mon_idx + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int start_cyc = 0;
  int lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int a = 0; a < 16384; a++) begin
      logic [7:0] x;
      x = 8'(a) ^ 8'h5A;
      if (mode == 0) begin
        res_mem[a] = x; g1_mem[a] = x; g2_mem[a] = ~x;
      end else if (mode == 1) begin
        res_mem[a] = x; g1_mem[a] = x ^ 8'h01; g2_mem[a] = x;
      end else begin
        res_mem[a] = 8'h00; g1_mem[a] = 8'h00; g2_mem[a] = 8'h00;
      end
    end
  endtask

  task automatic set_cfg(input int tw, input int th, input bit ge);
    i1.TW = 6'(tw); i1.TH = 6'(th); i1.GUARD_EN = ge;
    i3.TW = 6'(tw); i3.TH = 6'(th); i3.GUARD_EN = ge;
    i4.TW = 6'(tw); i4.TH = 6'(th); i4.GUARD_EN = ge;
  endtask

  task automatic do_start(input int s, input int tw, input int th, input bit ge);
    int k;
    @(negedge CLK);
    set_cfg(tw, th, ge);
    k = 0;
    for (int r = 0; r < th; r++)
      for (int c = 0; c < tw; c++) begin
        exp_ra[k & 127] = 14'(r * 128 + c);
        k++;
      end
    if (ge)
      for (int r = 100; r < 102; r++)
        for (int c = 0; c < 30; c++) begin
          exp_ra[k & 127] = 14'(r * 128 + c);
          k++;
        end
    rd_base  = mon_idx;
    bad_base = ra_bad;
    sel = s;
    if (s == 0) i1.START = 1'b1;
    else if (s == 1) i3.START = 1'b1;
    else i4.START = 1'b1;
    start_cyc = cyc + 1;
    @(negedge CLK);
    i1.START = 1'b0; i3.START = 1'b0; i4.START = 1'b0;
  endtask

  task automatic wait_done(output int l);
    int k;
    k = 0;
    while (s_done !== 1'b1 && k < 500) begin
      @(negedge CLK);
      k++;
    end
    l = (s_done === 1'b1) ? (cyc - start_cyc) : -1;
  endtask

  initial begin
    RST = 1'b0;
    i1.START = 1'b0; i3.START = 1'b0; i4.START = 1'b0;
    set_cfg(0, 0, 0);
    fill(2);
    repeat (3) @(negedge CLK);

    chk("rst_rd", 32'(s_rd), 0);
    chk("rst_ra", 32'(s_ra), 0);
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_done", 32'(s_done), 0);
    chk("rst_pass", 32'(s_pass), 0);
    chk("rst_cnt", 32'(s_cnt), 0);
    chk("rst_addr", 32'(s_addr), 0);
    chk("rst_ev", 32'(s_ev), 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // T1: result equals golden1 everywhere
    fill(0);
    do_start(0, 4, 4, 0);
    chk("t1_busy", 32'(s_busy), 1);
    wait_done(lat);
    chk("t1_lat", 32'(lat), 19);
    chk("t1_pass", 32'(s_pass), 1);
    chk("t1_cnt", 32'(s_cnt), 0);
    chk("t1_ev", 32'(s_ev), 0);
    chk("t1_addr", 32'(s_addr), 0);
    chk("t1_busy_end", 32'(s_busy), 0);
    chk("t1_nrd", 32'(mon_idx - rd_base), 16);
    chk("t1_ra", 32'(ra_bad - bad_base), 0);

    // T2: result matches golden2 only
    fill(1);
    do_start(0, 4, 4, 0);
    wait_done(lat);
    chk("t2_lat", 32'(lat), 19);
    chk("t2_pass", 32'(s_pass), 1);
    chk("t2_cnt", 32'(s_cnt), 0);

    // T3: two mismatches inside the window, two just outside it
    fill(0);
    res_mem[259] = res_mem[259] ^ 8'h01;
    res_mem[384] = res_mem[384] ^ 8'h01;
    res_mem[4]   = res_mem[4]   ^ 8'h01;
    res_mem[512] = res_mem[512] ^ 8'h01;
    do_start(0, 4, 4, 0);
    wait_done(lat);
    chk("t3_lat", 32'(lat), 19);
    chk("t3_cnt", 32'(s_cnt), 2);
    chk("t3_addr", 32'(s_addr), 259);
    chk("t3_ev", 32'(s_ev), 1);
    chk("t3_pass", 32'(s_pass), 0);

    // T4: empty window, guard band only
    fill(2);
    res_mem[12805] = 8'h07;
    do_start(0, 0, 0, 1);
    wait_done(lat);
    chk("t4_lat", 32'(lat), 63);
    chk("t4_nrd", 32'(mon_idx - rd_base), 60);
    chk("t4_ra", 32'(ra_bad - bad_base), 0);
    chk("t4_cnt", 32'(s_cnt), 1);
    chk("t4_addr", 32'(s_addr), 12805);
    chk("t4_pass", 32'(s_pass), 0);

    // T5a: START while busy is ignored
    fill(2);
    do_start(0, 4, 4, 0);
    repeat (4) @(negedge CLK);
    set_cfg(8, 8, 1);
    i1.START = 1'b1;
    @(negedge CLK);
    i1.START = 1'b0;
    wait_done(lat);
    chk("t5_lat", 32'(lat), 19);
    chk("t5_nrd", 32'(mon_idx - rd_base), 16);
    chk("t5_pass", 32'(s_pass), 1);

    // T5b: reset mid-window, then a clean rerun
    res_mem[0] = 8'h09;
    do_start(0, 4, 4, 0);
    repeat (5) @(negedge CLK);
    chk("t5_pre_cnt", 32'(s_cnt), 1);
    RST = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(s_busy), 0);
    chk("t5_rst_rd", 32'(s_rd), 0);
    chk("t5_rst_cnt", 32'(s_cnt), 0);
    chk("t5_rst_ev", 32'(s_ev), 0);
    chk("t5_rst_done", 32'(s_done), 0);
    @(negedge CLK);
    RST = 1'b1;
    res_mem[0] = 8'h00;
    do_start(0, 4, 4, 0);
    wait_done(lat);
    chk("t5_re_lat", 32'(lat), 19);
    chk("t5_re_nrd", 32'(mon_idx - rd_base), 16);
    chk("t5_re_cnt", 32'(s_cnt), 0);
    chk("t5_re_pass", 32'(s_pass), 1);

    // T6a: 4-bit counter saturates with 20 mismatches (pixels 1..20 of a 5x5 window)
    fill(2);
    for (int i = 1; i <= 20; i++) res_mem[(i / 5) * 128 + (i % 5)] = 8'h01;
    do_start(2, 5, 5, 0);
    wait_done(lat);
    chk("t6_lat", 32'(lat), 28);
    chk("t6_cnt", 32'(s_cnt), 15);
    chk("t6_addr", 32'(s_addr), 1);
    chk("t6_ev", 32'(s_ev), 1);
    chk("t6_pass", 32'(s_pass), 0);

    // T6b: T1 repeated with three-cycle memory latency
    fill(0);
    do_start(1, 4, 4, 0);
    wait_done(lat);
    chk("t6_l3_lat", 32'(lat), 21);
    chk("t6_l3_pass", 32'(s_pass), 1);
    chk("t6_l3_cnt", 32'(s_cnt), 0);
    chk("t6_l3_nrd", 32'(mon_idx - rd_base), 16);
    chk("t6_l3_ra", 32'(ra_bad - bad_base), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
